msp430_dbg_brk_seq: RTL and testbench

//  Trigger sequencer between the hardware breakpoint units and the debug core halt logic.

---
 rtl/msp430_dbg_brk_seq_pkg.sv | 20 ++
 rtl/msp430_dbg_brk_seq.sv | 107 ++++++++++
 tb/tb_msp430_dbg_brk_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/msp430_dbg_brk_seq_pkg.sv
// Shared definitions for the breakpoint trigger sequencer: register indices,
// control bit positions and the 2-bit sequencer state encoding.
package msp430_dbg_brk_seq_pkg;

  localparam int SEQ_CTL_IDX    = 0;
  localparam int SEQ_CNT_IDX    = 1;
  localparam int SEQ_HIT_IDX    = 2;

  localparam int SEQ_EN_BIT     = 0;
  localparam int CHAIN_EN_BIT   = 1;
  localparam int AUTO_REARM_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STAGE0 = 2'b01,
    ST_STAGE1 = 2'b10,
    ST_FIRED  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/msp430_dbg_brk_seq.sv
// Breakpoint trigger sequencer: qualifies raw hwbrk halt requests with a
// pass count on unit 0 and an optional unit0-then-unit1 chain.
module msp430_dbg_brk_seq
  import msp430_dbg_brk_seq_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 dbg_clk,
  input  logic                 dbg_rst,
  input  logic [2:0]           seq_reg_rd,
  input  logic [2:0]           seq_reg_wr,
  input  logic [15:0]          dbg_din,
  input  logic [NUM_UNITS-1:0] brk_halt_in,
  output logic [15:0]          seq_dout,
  output logic                 brk_halt,
  output logic                 seq_fired
);

  logic [2:0]       ctl;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hit, hit_nxt;
  seq_state_e       state, state_nxt;
  logic             halt_q, halt_nxt;

  logic seq_en, chain_en, auto_rearm, ctl_wr, cnt_wr;
  logic [NUM_UNITS-1:0] pass_mask;
  logic [15:0] ctl_rd;

  assign seq_en     = ctl[SEQ_EN_BIT];
  assign chain_en   = ctl[CHAIN_EN_BIT];
  assign auto_rearm = ctl[AUTO_REARM_BIT];
  assign ctl_wr     = seq_reg_wr[SEQ_CTL_IDX];
  assign cnt_wr     = seq_reg_wr[SEQ_CNT_IDX];

  always_ff @(posedge dbg_clk) begin
    if (dbg_rst) begin
      ctl    <= '0;
      cnt    <= '0;
      hit    <= '0;
      state  <= ST_IDLE;
      halt_q <= 1'b0;
    end else begin
      if (ctl_wr) ctl <= dbg_din[2:0];
      if (cnt_wr) cnt <= dbg_din[CNT_W-1:0];
      hit    <= hit_nxt;
      state  <= state_nxt;
      halt_q <= halt_nxt;
    end
  end

  // halt_nxt flags entry into FIRED so the pulse lands the cycle after the qualifying hit
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit;
    halt_nxt  = 1'b0;
    if (ctl_wr) begin
      hit_nxt   = '0;
      state_nxt = dbg_din[SEQ_EN_BIT] ? ST_STAGE0 : ST_IDLE;
    end else if (!seq_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_STAGE0;
        ST_STAGE0: begin
          if (brk_halt_in[0]) begin
            if (hit >= cnt) begin
              state_nxt = chain_en ? ST_STAGE1 : ST_FIRED;
              halt_nxt  = !chain_en;
            end else if (hit != '1) begin
              hit_nxt = hit + 1'b1;
            end
          end
        end
        ST_STAGE1: begin
          if (brk_halt_in[1]) begin
            state_nxt = ST_FIRED;
            halt_nxt  = 1'b1;
          end
        end
        ST_FIRED: begin
          if (auto_rearm) begin
            state_nxt = ST_STAGE0;
            hit_nxt   = '0;
          end
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Units outside the sequence pass straight through to the halt line
  always_comb begin
    pass_mask    = '1;
    pass_mask[0] = 1'b0;
    if (chain_en) pass_mask[1] = 1'b0;
  end

  assign brk_halt  = seq_en ? (halt_q | (|(brk_halt_in & pass_mask))) : (|brk_halt_in);
  assign seq_fired = (state == ST_FIRED);

  assign ctl_rd   = {10'b0, state, 1'b0, ctl};
  assign seq_dout = (ctl_rd     & {16{seq_reg_rd[SEQ_CTL_IDX]}})
                  | (16'(cnt)   & {16{seq_reg_rd[SEQ_CNT_IDX]}})
                  | (16'(hit)   & {16{seq_reg_rd[SEQ_HIT_IDX]}});

endmodule

// File: tb/tb_msp430_dbg_brk_seq.sv
// Directed bench for the breakpoint sequencer: a cycle-by-cycle vector table
// for the main instance plus a hand-written pass-count run on a 4-bit instance.
module tb_msp430_dbg_brk_seq;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_CTL  = 3'b001;
  localparam logic [2:0] R_CNT  = 3'b010;
  localparam logic [2:0] R_HIT  = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd, wr;
  logic [15:0] din;
  logic [3:0]  hin;
  logic [15:0] dout;
  logic        halt, fired;

  logic [2:0]  s_rd, s_wr;
  logic [15:0] s_din;
  logic [1:0]  s_hin;
  logic [15:0] s_dout;
  logic        s_halt, s_fired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msp430_dbg_brk_seq #(.NUM_UNITS(4), .CNT_W(16)) u_dut (
    .dbg_clk(clk), .dbg_rst(rst), .seq_reg_rd(rd), .seq_reg_wr(wr),
    .dbg_din(din), .brk_halt_in(hin), .seq_dout(dout),
    .brk_halt(halt), .seq_fired(fired)
  );

  msp430_dbg_brk_seq #(.NUM_UNITS(2), .CNT_W(4)) u_sat (
    .dbg_clk(clk), .dbg_rst(rst), .seq_reg_rd(s_rd), .seq_reg_wr(s_wr),
    .dbg_din(s_din), .brk_halt_in(s_hin), .seq_dout(s_dout),
    .brk_halt(s_halt), .seq_fired(s_fired)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [15:0] din;
    logic [3:0]  hin;
    logic [15:0] dout;
    logic        halt;
    logic        fired;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [2:0] rsel, input logic [2:0] wsel,
                     input logic [15:0] d, input logic [3:0] h,
                     input logic [15:0] edout, input logic ehalt, input logic efired);
    vec_t v;
    v.rst = r; v.rd = rsel; v.wr = wsel; v.din = d; v.hin = h;
    v.dout = edout; v.halt = ehalt; v.fired = efired;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic sstep(input logic [2:0] rsel, input logic [2:0] wsel,
                       input logic [15:0] d, input logic [1:0] h);
    @(posedge clk); #1;
    s_rd = rsel; s_wr = wsel; s_din = d; s_hin = h;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rd = '0; wr = '0; din = '0; hin = '0;
    s_rd = '0; s_wr = '0; s_din = '0; s_hin = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state: every readable register and both outputs are 0
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      rd = 3'(1 << i);
      @(negedge clk);
      chk("reset_dout", i, dout, 16'h0);
      chk("reset_halt", i, 16'(halt), 16'h0);
      chk("reset_fired", i, 16'(fired), 16'h0);
    end

    // bypass
    add(0, R_CTL, R_NONE, 0, 4'b0100, 16'h0000, 1, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    // pass count P=3
    add(0, R_CTL, R_CTL, 16'h0001, 4'b0000, 16'h0000, 0, 0);
    add(0, R_CTL, R_CNT, 16'h0003, 4'b0000, 16'h0011, 0, 0);
    add(0, R_CNT, R_NONE, 0, 4'b0001, 16'h0003, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0001, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0001, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0002, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0002, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0003, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0001, 16'h0011, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0031, 1, 1);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0031, 0, 1);
    add(0, R_HIT, R_NONE, 0, 4'b0100, 16'h0003, 1, 1);
    // chain, P=0
    add(0, R_HIT, R_CTL, 16'h0003, 4'b0000, 16'h0003, 0, 1);
    add(0, R_CTL, R_CNT, 16'h0000, 4'b0000, 16'h0013, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0010, 16'h0013, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0001, 16'h0013, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0023, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0010, 16'h0000, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0033, 1, 1);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0033, 0, 1);
    // auto-rearm, P=1
    add(0, R_CTL, R_CTL, 16'h0005, 4'b0000, 16'h0033, 0, 1);
    add(0, R_CTL, R_CNT, 16'h0001, 4'b0000, 16'h0015, 0, 0);
    add(0, R_CNT, R_NONE, 0, 4'b0010, 16'h0001, 1, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0000, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0001, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0035, 1, 1);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0001, 16'h0015, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0001, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0001, 1, 1);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    // CTL write coincident with a qualifying hit
    add(0, R_CTL, R_CNT, 16'h0000, 4'b0000, 16'h0015, 0, 0);
    add(0, R_HIT, R_CTL, 16'h0001, 4'b0001, 16'h0000, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0011, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    // lowering P below H mid-sequence
    add(0, R_HIT, R_CNT, 16'h0005, 4'b0000, 16'h0000, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0000, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0001, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0001, 16'h0002, 0, 0);
    add(0, R_HIT, R_CNT, 16'h0001, 4'b0000, 16'h0003, 0, 0);
    add(0, R_CNT, R_NONE, 0, 4'b0001, 16'h0001, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0031, 1, 1);
    // reach STAGE1 with H=7, then reset with a unit1 hit pending
    add(0, R_CTL, R_CTL, 16'h0003, 4'b0000, 16'h0031, 0, 1);
    add(0, R_CTL, R_CNT, 16'h0007, 4'b0000, 16'h0013, 0, 0);
    for (int i = 0; i < 8; i++) add(0, R_HIT, R_NONE, 0, 4'b0001, 16'(i), 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0023, 0, 0);
    add(1, R_HIT, R_NONE, 0, 4'b0010, 16'h0007, 0, 0);
    add(0, R_CTL, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    add(0, R_CNT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    add(0, R_HIT, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);
    add(0, R_NONE, R_NONE, 0, 4'b0000, 16'h0000, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      rst = vq[i].rst; rd = vq[i].rd; wr = vq[i].wr; din = vq[i].din; hin = vq[i].hin;
      @(negedge clk);
      chk("vec_dout", i, dout, vq[i].dout);
      chk("vec_halt", i, 16'(halt), 16'(vq[i].halt));
      chk("vec_fired", i, 16'(fired), 16'(vq[i].fired));
    end
    @(posedge clk); #1;
    rst = 1'b0; rd = '0; wr = '0; din = '0; hin = '0;

    // 4-bit counter: P=15 via an over-wide write, H climbs to all-ones then fires
    sstep(R_NONE, R_CTL, 16'h0001, 2'b00);
    sstep(R_NONE, R_CNT, 16'hFFFF, 2'b00);
    sstep(R_CNT, R_NONE, 16'h0, 2'b00);
    chk("sat_cnt", 0, s_dout, 16'h000F);
    for (int i = 0; i < 15; i++) begin
      sstep(R_HIT, R_NONE, 16'h0, 2'b01);
      chk("sat_halt_early", i, 16'(s_halt), 16'h0);
    end
    sstep(R_HIT, R_NONE, 16'h0, 2'b00);
    chk("sat_hit15", 0, s_dout, 16'h000F);
    sstep(R_HIT, R_NONE, 16'h0, 2'b01);
    chk("sat_fire_cycle", 0, 16'(s_halt), 16'h0);
    sstep(R_HIT, R_NONE, 16'h0, 2'b00);
    chk("sat_halt", 0, 16'(s_halt), 16'h1);
    chk("sat_fired", 0, 16'(s_fired), 16'h1);
    chk("sat_hit_hold", 0, s_dout, 16'h000F);
    sstep(R_CTL, R_NONE, 16'h0, 2'b00);
    chk("sat_ctl", 0, s_dout, 16'h0031);
    chk("sat_halt_off", 0, 16'(s_halt), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
